// File: rtl/pll_lock_sequencer.sv
// PLL bring-up controller on the reference clock: holds the PLL in reset, waits for a synchronized lock,
// releases the core after lock is stable, retries on timeout, and latches a fault after too many retries.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_in,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    MAX_R       = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Outputs are assigned on the same edge that enters a state, so they track state with no lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      core_rst_n      <= 1'b0;
      ready           <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count == MAX_R) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state       <= PLL_RESET;
              retry_count <= retry_count + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABILIZE: begin
          // A dropout here only restarts the lock wait; it is not charged as a retry.
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            core_rst_n  <= 1'b1;
            ready       <= 1'b1;
            retry_count <= 4'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state      <= PLL_RESET;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            core_rst_n <= 1'b0;
            ready      <= 1'b0;
            if (lock_loss_count != 8'hFF) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            fault       <= 1'b0;
            retry_count <= 4'd0;
          end
        end
        default: begin
          state      <= PLL_RESET;
          cnt        <= '0;
          pll_rst    <= 1'b1;
          core_rst_n <= 1'b0;
          ready      <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with short timing parameters; expected event cycles are queued on stimulus.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked_in;
  logic       clear_fault;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         off;
    logic [3:0] retry;
    logic       flt;
  } ev_t;

  ev_t sb[$];
  int  exp_q[$];

  pll_lock_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked_in(locked_in), .clear_fault(clear_fault),
    .pll_rst(pll_rst), .core_rst_n(core_rst_n), .ready(ready), .fault(fault),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_core(input logic val, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (core_rst_n === val) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked_in = 1'b0; clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
    total++; if (lock_loss_count !== 8'd0) begin bad++; $display("FAIL reset_llc got=%0d exp=0", lock_loss_count); end
  endtask

  task automatic test_bringup();
    int hi, at, e;
    bit ok;
    do_reset();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (pll_rst === 1'b1) hi++;
    end
    total++; if (hi != 4) begin bad++; $display("FAIL bringup_pll_rst_width got=%0d exp=4", hi); end
    @(negedge clk);
    locked_in = 1'b1;
    exp_q.push_back(cyc + 11);
    wait_core(1'b1, at, ok);
    e = exp_q.pop_front();
    total++; if (!ok || at != e) begin bad++; $display("FAIL bringup_release_cycle got=%0d exp=%0d", at, e); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL bringup_ready got=%b exp=1", ready); end
    total++; if (retry_count !== 4'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL bringup_retry_fault got=%0d/%b exp=0/0", retry_count, fault);
    end
  endtask

  task automatic test_stabilize_abort();
    int at, e;
    bit ok;
    do_reset();
    locked_in = 1'b0;
    repeat (6) @(negedge clk);
    locked_in = 1'b1;
    repeat (5) @(negedge clk);
    locked_in = 1'b0;
    repeat (3) @(negedge clk);
    locked_in = 1'b1;
    exp_q.push_back(cyc + 11);
    wait_core(1'b1, at, ok);
    e = exp_q.pop_front();
    total++; if (!ok || at != e) begin bad++; $display("FAIL abort_release_cycle got=%0d exp=%0d", at, e); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL abort_retry got=%0d exp=0", retry_count); end
  endtask

  task automatic test_timeout_fault();
    int run, hi;
    logic prev;
    ev_t ev;
    locked_in = 1'b0;
    do_reset();
    sb.push_back('{off: 24, retry: 4'd1, flt: 1'b0});
    sb.push_back('{off: 48, retry: 4'd2, flt: 1'b0});
    sb.push_back('{off: 72, retry: 4'd2, flt: 1'b1});
    prev = pll_rst;
    run  = 1;
    for (int off = 1; off <= 84; off++) begin
      @(negedge clk);
      clear_fault = (off == 30);
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL timeout_extra_rise got=off%0d exp=none", off);
        end else begin
          ev = sb.pop_front();
          if (off != ev.off || retry_count !== ev.retry || fault !== ev.flt) begin
            bad++;
            $display("FAIL timeout_event got=off%0d retry%0d fault%b exp=off%0d retry%0d fault%b",
                     off, retry_count, fault, ev.off, ev.retry, ev.flt);
          end
        end
        run = 0;
      end
      if (pll_rst === 1'b1) run++;
      else if (prev === 1'b1) begin
        total++; if (run != 4) begin bad++; $display("FAIL timeout_pulse_width got=%0d exp=4", run); end
      end
      prev = pll_rst;
    end
    clear_fault = 1'b0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL timeout_missing_events got=%0d exp=0", sb.size()); end
    total++; if (fault !== 1'b1 || pll_rst !== 1'b1) begin
      bad++; $display("FAIL fault_held got=%b/%b exp=1/1", fault, pll_rst);
    end
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    total++; if (fault !== 1'b0 || retry_count !== 4'd0) begin
      bad++; $display("FAIL clear_fault got=%b/%0d exp=0/0", fault, retry_count);
    end
    hi = (pll_rst === 1'b1) ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (pll_rst === 1'b1) hi++;
    end
    total++; if (hi != 4) begin bad++; $display("FAIL clear_reset_width got=%0d exp=4", hi); end
  endtask

  task automatic test_lock_loss();
    int at, e, hi;
    bit ok, all_ok;
    do_reset();
    locked_in = 1'b1;
    wait_core(1'b1, at, ok);
    total++; if (!ok) begin bad++; $display("FAIL loss_initial_lock got=timeout exp=release"); end
    @(negedge clk);
    locked_in = 1'b0;
    exp_q.push_back(cyc + 3);
    wait_core(1'b0, at, ok);
    e = exp_q.pop_front();
    total++; if (!ok || at != e) begin bad++; $display("FAIL loss_drop_cycle got=%0d exp=%0d", at, e); end
    total++; if (ready !== 1'b0 || lock_loss_count !== 8'd1) begin
      bad++; $display("FAIL loss_ready_llc got=%b/%0d exp=0/1", ready, lock_loss_count);
    end
    hi = (pll_rst === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (pll_rst === 1'b1) hi++;
    end
    total++; if (hi != 4) begin bad++; $display("FAIL loss_pll_rst_width got=%0d exp=4", hi); end
    locked_in = 1'b1;
    exp_q.push_back(cyc + 11);
    wait_core(1'b1, at, ok);
    e = exp_q.pop_front();
    total++; if (!ok || at != e) begin bad++; $display("FAIL loss_relock_cycle got=%0d exp=%0d", at, e); end
    all_ok = 1'b1;
    for (int i = 2; i <= 256; i++) begin
      @(negedge clk);
      locked_in = 1'b0;
      wait_core(1'b0, at, ok);
      all_ok &= ok;
      if (i == 255) begin
        total++; if (lock_loss_count !== 8'd255) begin bad++; $display("FAIL llc_reach_255 got=%0d exp=255", lock_loss_count); end
      end
      if (i == 256) begin
        total++; if (lock_loss_count !== 8'd255) begin bad++; $display("FAIL llc_saturate got=%0d exp=255", lock_loss_count); end
      end
      @(negedge clk);
      locked_in = 1'b1;
      wait_core(1'b1, at, ok);
      all_ok &= ok;
    end
    total++; if (!all_ok) begin bad++; $display("FAIL loss_loop_waits got=timeout exp=all_events"); end
  endtask

  task automatic test_async_reset();
    int at, e;
    bit ok;
    @(negedge clk);
    locked_in = 1'b0;
    wait_core(1'b0, at, ok);
    @(negedge clk);
    locked_in = 1'b1;
    repeat (7) @(negedge clk);
    total++; if (pll_rst !== 1'b0 || core_rst_n !== 1'b0) begin
      bad++; $display("FAIL async_pre_stabilize got=%b/%b exp=0/0", pll_rst, core_rst_n);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (pll_rst !== 1'b1 || core_rst_n !== 1'b0 || ready !== 1'b0) begin
      bad++; $display("FAIL async_outputs got=%b/%b/%b exp=1/0/0", pll_rst, core_rst_n, ready);
    end
    total++; if (lock_loss_count !== 8'd0 || retry_count !== 4'd0) begin
      bad++; $display("FAIL async_counters got=%0d/%0d exp=0/0", lock_loss_count, retry_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(cyc + 13);
    wait_core(1'b1, at, ok);
    e = exp_q.pop_front();
    total++; if (!ok || at != e) begin bad++; $display("FAIL async_restart_cycle got=%0d exp=%0d", at, e); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stabilize_abort();
    test_timeout_fault();
    test_lock_loss();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
